// File: rtl/conj_axpy_pkg.sv
// Shared types and helpers for the conjugate complex AXPY stream kernel.
// Holds the run FSM encoding, the op encoding and small sizing helpers.
// No logic, no state; imported by the lane datapath and the top level.
package conj_axpy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of one complex element {re, im}.
  function automatic int elem_w(input int comp_w);
    return 2 * comp_w;
  endfunction

  // Number of beats needed to carry n elements at ni lanes per beat.
  function automatic int unsigned ceil_beats(input int unsigned n, input int unsigned ni);
    return (n + ni - 1) / ni;
  endfunction

endpackage

// File: rtl/conj_axpy_lane.sv
// One lane: r = b +/- conj(a)*k in Q(COMP_W-FRAC).FRAC fixed point; CONJ_AXPY_SAT_EN selects saturation over wrap.
// Latency: 3 cycles (partial products, sum+shift, add/sub), b delayed 2 cycles to stay aligned.
// Backpressure: every register advances only when en is high; en low freezes the whole lane.
module conj_axpy_lane
  import conj_axpy_pkg::*;
#(
  parameter int COMP_W = 16,
  parameter int FRAC   = 8,
  localparam int EW    = elem_w(COMP_W)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          op,
  input  logic [EW-1:0] k,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [EW-1:0] r
);

  localparam int PW = 2 * COMP_W;
  localparam int SW = 2 * COMP_W + 1;

  logic signed [COMP_W-1:0] ar, ai, kr, ki;
  logic signed [PW-1:0]     pp_rr, pp_ii, pp_ri, pp_ir;
  logic signed [SW-1:0]     sum_re, sum_im;
  logic signed [COMP_W-1:0] p_re, p_im;
  logic signed [COMP_W-1:0] p_re_n, p_im_n, r_re_n, r_im_n;
  logic [EW-1:0]            b1, b2;

  assign ar = a[EW-1:COMP_W];
  assign ai = a[COMP_W-1:0];
  assign kr = k[EW-1:COMP_W];
  assign ki = k[COMP_W-1:0];

  // conj(a)*k = (ar*kr + ai*ki) + j(ar*ki - ai*kr); the extra bit keeps the sum exact.
  assign sum_re = SW'(pp_rr) + SW'(pp_ii);
  assign sum_im = SW'(pp_ri) - SW'(pp_ir);

  function automatic logic signed [SW-1:0] addsub(input logic sub,
                                                 input logic signed [COMP_W-1:0] x,
                                                 input logic signed [COMP_W-1:0] y);
    return sub ? (SW'(x) - SW'(y)) : (SW'(x) + SW'(y));
  endfunction

`ifdef CONJ_AXPY_SAT_EN
  localparam logic signed [SW-1:0] SMAX = SW'(2 ** (COMP_W - 1) - 1);
  localparam logic signed [SW-1:0] SMIN = -SMAX - 1;

  function automatic logic signed [COMP_W-1:0] fit(input logic signed [SW-1:0] v);
    if (v > SMAX)      return COMP_W'(SMAX);
    else if (v < SMIN) return COMP_W'(SMIN);
    else               return COMP_W'(v);
  endfunction

  assign p_re_n = fit(sum_re >>> FRAC);
  assign p_im_n = fit(sum_im >>> FRAC);
  assign r_re_n = fit(addsub(op == OP_SUB, b2[EW-1:COMP_W], p_re));
  assign r_im_n = fit(addsub(op == OP_SUB, b2[COMP_W-1:0], p_im));
`else
  assign p_re_n = COMP_W'(sum_re >>> FRAC);
  assign p_im_n = COMP_W'(sum_im >>> FRAC);
  assign r_re_n = COMP_W'(addsub(op == OP_SUB, b2[EW-1:COMP_W], p_re));
  assign r_im_n = COMP_W'(addsub(op == OP_SUB, b2[COMP_W-1:0], p_im));
`endif

  // S1: register the four partial products and the first b delay.
  always_ff @(posedge clk) begin
    if (en) begin
      pp_rr <= PW'(ar) * PW'(kr);
      pp_ii <= PW'(ai) * PW'(ki);
      pp_ri <= PW'(ar) * PW'(ki);
      pp_ir <= PW'(ai) * PW'(kr);
      b1    <= b;
    end
  end

  // S2: register the shifted, width-reduced product and the second b delay.
  always_ff @(posedge clk) begin
    if (en) begin
      p_re <= p_re_n;
      p_im <= p_im_n;
      b2   <= b1;
    end
  end

  // S3: register the final add/sub result.
  always_ff @(posedge clk) begin
    if (en) begin
      r <= {r_re_n, r_im_n};
    end
  end

endmodule

// File: rtl/conjugate_complex_axpy_stream.sv
// Streaming r = b +/- conj(a)*k over NI lanes per beat for a run-time vector length; CONJ_AXPY_SAT_EN enables saturation.
// Latency: 3 cycles from input accept to out_valid, 1 beat/cycle sustained.
// Backpressure: global stall when out_valid & !out_ready; in_ready drops and all stages hold.
module conjugate_complex_axpy_stream
  import conj_axpy_pkg::*;
#(
  parameter int NI     = 8,
  parameter int COMP_W = 16,
  parameter int FRAC   = 8,
  parameter int LEN_W  = 16,
  localparam int EW    = elem_w(COMP_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [EW-1:0]    constant,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW*NI-1:0] first_row_input,
  input  logic [EW*NI-1:0] second_row_input,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW*NI-1:0] result,
  output logic [NI-1:0]    out_mask,
  output logic             busy,
  output logic             finish
);

  state_t           state, state_n;
  logic             op_q;
  logic [EW-1:0]    k_q;
  logic [LEN_W-1:0] total_q, beats_in;
  logic [NI-1:0]    last_mask_q, last_mask_n;
  logic             advance, accept, last_in, start_ok;
  logic             v1, v2, v3, l1, l2, l3;
  logic [NI-1:0]    m1, m2, m3;
  logic [EW-1:0]    lane_r [NI];

  assign start_ok  = start && (state == IDLE);
  assign advance   = !v3 || out_ready;
  assign in_ready  = (state == RUN) && advance && (beats_in < total_q);
  assign accept    = in_valid && in_ready;
  assign last_in   = (beats_in == total_q - LEN_W'(1));
  assign out_valid = v3;
  assign out_mask  = m3;
  assign busy      = (state != IDLE);
  assign finish    = (state == DONE);

  // Lane mask of the final beat: lanes 0..(N-1)%NI carry real elements.
  always_comb begin
    int unsigned rem;
    rem = (32'(vec_len) + 32'(NI) - 1) % 32'(NI);
    last_mask_n = '0;
    for (int j = 0; j < NI; j++) begin
      last_mask_n[j] = (unsigned'(j) <= rem);
    end
  end

  // Run parameters are captured once per run at the accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q        <= OP_ADD;
      k_q         <= '0;
      total_q     <= '0;
      last_mask_q <= '0;
    end else if (start_ok) begin
      op_q        <= op;
      k_q         <= constant;
      total_q     <= LEN_W'(ceil_beats(32'(vec_len), 32'(NI)));
      last_mask_q <= last_mask_n;
    end
  end

  // Count accepted input beats within the run.
  always_ff @(posedge clk) begin
    if (!reset)        beats_in <= '0;
    else if (start_ok) beats_in <= '0;
    else if (accept)   beats_in <= beats_in + LEN_W'(1);
  end

  // Valid / last / mask pipeline shadowing the lane datapath stages.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {v1, v2, v3} <= '0;
      {l1, l2, l3} <= '0;
      m1 <= '0;
      m2 <= '0;
      m3 <= '0;
    end else if (advance) begin
      v1 <= accept;
      l1 <= accept && last_in;
      m1 <= !accept ? '0 : (last_in ? last_mask_q : '1);
      v2 <= v1;
      l2 <= l1;
      m2 <= m1;
      v3 <= v2;
      l3 <= l2;
      m3 <= m2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state: RUN until the last beat is taken, DRAIN until it leaves, one DONE cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (vec_len == '0) ? DONE : RUN;
      RUN:     if (accept && last_in) state_n = DRAIN;
      DRAIN:   if (v3 && l3 && out_ready) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  for (genvar j = 0; j < NI; j++) begin : g_lane
    conj_axpy_lane #(
      .COMP_W (COMP_W),
      .FRAC   (FRAC)
    ) u_lane (
      .clk (clk),
      .en  (advance),
      .op  (op_q),
      .k   (k_q),
      .a   (first_row_input[EW*(NI-j)-1 -: EW]),
      .b   (second_row_input[EW*(NI-j)-1 -: EW]),
      .r   (lane_r[j])
    );
    assign result[EW*(NI-j)-1 -: EW] = (v3 && m3[j]) ? lane_r[j] : '0;
  end

endmodule

// File: tb/tb_conjugate_complex_axpy_stream.sv
// Directed bench for conjugate_complex_axpy_stream: vector table plus run-level sequences.
// Expected lane values are hand-computed in Q8.8 (1.0 = 0x0100).
// Prints one summary line with check and error counts.
module tb_conjugate_complex_axpy_stream;

  localparam int NI = 8, COMP_W = 16, FRAC = 8, LEN_W = 16;
  localparam int EW = 2 * COMP_W;
  localparam int BW = EW * NI;

  logic             clk = 1'b0;
  logic             reset, start, op, in_valid, out_ready;
  logic [EW-1:0]    constant;
  logic [LEN_W-1:0] vec_len;
  logic [BW-1:0]    first_row_input, second_row_input;
  logic             in_ready, out_valid, busy, finish;
  logic [BW-1:0]    result;
  logic [NI-1:0]    out_mask;

  always #5 clk = ~clk;

  conjugate_complex_axpy_stream #(
    .NI(NI), .COMP_W(COMP_W), .FRAC(FRAC), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .constant(constant),
    .vec_len(vec_len), .in_valid(in_valid), .in_ready(in_ready),
    .first_row_input(first_row_input), .second_row_input(second_row_input),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_mask(out_mask), .busy(busy), .finish(finish)
  );

  typedef struct {
    logic        op;
    logic [15:0] kr, ki, ar, ai, br, bi;
    int          n;
    logic [15:0] er, ei;
  } vec_t;

  vec_t tbl [7];

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] a_q[$], b_q[$], e_q[$];
  logic [NI-1:0] m_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every lane carries the same a, b; expected is the table value on real lanes, 0 on padding lanes.
  task automatic fill_uniform(input vec_t v);
    int nb;
    logic [BW-1:0] ab, bb, eb;
    logic [NI-1:0] mb;
    a_q.delete(); b_q.delete(); e_q.delete(); m_q.delete();
    nb = (v.n + NI - 1) / NI;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < NI; j++) begin
        ab[EW*(NI-j)-1 -: EW] = {v.ar, v.ai};
        bb[EW*(NI-j)-1 -: EW] = {v.br, v.bi};
        mb[j] = (i * NI + j < v.n);
        eb[EW*(NI-j)-1 -: EW] = mb[j] ? {v.er, v.ei} : 32'h0;
      end
      a_q.push_back(ab); b_q.push_back(bb); e_q.push_back(eb); m_q.push_back(mb);
    end
  endtask

  // Distinct b per element; a is uniform with a hand-derived product p, so r = b +/- p.
  task automatic fill_seq(input int n, input logic [31:0] a_el, input logic [15:0] p_re,
                          input logic [15:0] p_im, input logic sub);
    int nb, e;
    logic [15:0] bre, bim;
    logic [BW-1:0] ab, bb, eb;
    logic [NI-1:0] mb;
    a_q.delete(); b_q.delete(); e_q.delete(); m_q.delete();
    nb = (n + NI - 1) / NI;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < NI; j++) begin
        e = i * NI + j;
        bre = 16'(e * 5 + 3);
        bim = 16'(1000 - e * 7);
        ab[EW*(NI-j)-1 -: EW] = a_el;
        bb[EW*(NI-j)-1 -: EW] = {bre, bim};
        mb[j] = (e < n);
        if (!mb[j])  eb[EW*(NI-j)-1 -: EW] = 32'h0;
        else if (sub) eb[EW*(NI-j)-1 -: EW] = {bre - p_re, bim - p_im};
        else          eb[EW*(NI-j)-1 -: EW] = {bre + p_re, bim + p_im};
      end
      a_q.push_back(ab); b_q.push_back(bb); e_q.push_back(eb); m_q.push_back(mb);
    end
  endtask

  // One complete run: start, feed the queued beats, score outputs, finish and stall behaviour.
  task automatic run(input logic op_i, input logic [EW-1:0] k_i, input int n,
                     input bit stall, input string tag);
    int nb, in_idx, out_idx, fin, fin_cyc, acc_cyc, ov_cyc;
    bit prev_st;
    logic [BW-1:0] prev_res;
    logic [NI-1:0] prev_m;
    nb = (n + NI - 1) / NI;
    in_idx = 0; out_idx = 0; fin = 0; fin_cyc = -1; acc_cyc = -1; ov_cyc = -1;
    prev_st = 1'b0; prev_res = '0; prev_m = '0;
    @(negedge clk);
    start = 1'b1; op = op_i; constant = k_i; vec_len = LEN_W'(n); out_ready = 1'b1;
    in_valid = (nb > 0);
    if (nb > 0) begin first_row_input = a_q[0]; second_row_input = b_q[0]; end
    #1;
    chk({tag, "_in_ready_start_cycle"}, 256'(in_ready), 256'(0));
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (in_idx < nb) begin
        in_valid = 1'b1; first_row_input = a_q[in_idx]; second_row_input = b_q[in_idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 0) chk({tag, "_busy"}, 256'(busy), 256'(1));
      if (prev_st) begin
        chk({tag, "_hold_valid"}, 256'(out_valid), 256'(1));
        chk({tag, "_hold_result"}, 256'(result), 256'(prev_res));
        chk({tag, "_hold_mask"}, 256'(out_mask), 256'(prev_m));
      end
      if (out_valid && !out_ready) chk({tag, "_in_ready_stalled"}, 256'(in_ready), 256'(0));
      if (out_valid && ov_cyc < 0) ov_cyc = cyc;
      if (out_valid && out_ready) begin
        if (out_idx < nb) begin
          chk($sformatf("%s_result_beat%0d", tag, out_idx), 256'(result), 256'(e_q[out_idx]));
          chk($sformatf("%s_mask_beat%0d", tag, out_idx), 256'(out_mask), 256'(m_q[out_idx]));
        end else begin
          checks++; errors++;
          $display("FAIL %s_extra_beat: got beat %0d expected only %0d beats", tag, out_idx, nb);
        end
        out_idx++;
      end
      if (finish) begin
        fin++;
        if (fin_cyc < 0) fin_cyc = cyc;
        chk({tag, "_drained_at_finish"}, 256'(out_idx), 256'(nb));
      end
      prev_st = out_valid && !out_ready;
      prev_res = result;
      prev_m = out_mask;
      if (in_valid && in_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        in_idx++;
      end
      if (fin_cyc >= 0 && cyc >= fin_cyc + 3) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_finish_count"}, 256'(fin), 256'(1));
    chk({tag, "_beats_in"}, 256'(in_idx), 256'(nb));
    chk({tag, "_beats_out"}, 256'(out_idx), 256'(nb));
    chk({tag, "_busy_after"}, 256'(busy), 256'(0));
    if (!stall && nb > 0) chk({tag, "_latency"}, 256'(ov_cyc - acc_cyc), 256'(3));
    if (nb == 0) chk({tag, "_finish_cycle"}, 256'(fin_cyc), 256'(0));
  endtask

  initial begin
    //        op    kr       ki       ar       ai       br       bi       n   er       ei
    tbl[0] = '{1'b0, 16'h0300, 16'h0100, 16'h0100, 16'h0200, 16'h0100, 16'h0100, 8,  16'h0600, 16'hFC00};
    tbl[1] = '{1'b1, 16'h0300, 16'h0100, 16'h0100, 16'h0200, 16'h0100, 16'h0100, 8,  16'hFC00, 16'h0600};
`ifdef CONJ_AXPY_SAT_EN
    tbl[2] = '{1'b0, 16'h0200, 16'h0000, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 8,  16'h7FFF, 16'h0000};
    tbl[6] = '{1'b0, 16'h0200, 16'h0000, 16'h8000, 16'h0000, 16'hFF00, 16'h0000, 8,  16'h8000, 16'h0000};
`else
    tbl[2] = '{1'b0, 16'h0200, 16'h0000, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 8,  16'h7D00, 16'h0000};
    tbl[6] = '{1'b0, 16'h0200, 16'h0000, 16'h8000, 16'h0000, 16'hFF00, 16'h0000, 8,  16'hFF00, 16'h0000};
`endif
    tbl[3] = '{1'b0, 16'h0200, 16'h0040, 16'h0080, 16'hFE80, 16'h0000, 16'h0000, 8,  16'h00A0, 16'h0320};
    tbl[4] = '{1'b0, 16'hFF80, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 12, 16'hFFFF, 16'h0000};
    tbl[5] = '{1'b1, 16'h0100, 16'hFF00, 16'hFE00, 16'h0300, 16'h0500, 16'h0500, 8,  16'h0A00, 16'h0600};

    reset = 1'b0; start = 1'b0; op = 1'b0; constant = '0; vec_len = '0;
    in_valid = 1'b0; out_ready = 1'b1; first_row_input = '0; second_row_input = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", 256'(in_ready), 256'(0));
    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_result", 256'(result), 256'(0));
    chk("reset_out_mask", 256'(out_mask), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_finish", 256'(finish), 256'(0));
    reset = 1'b1;

    for (int t = 0; t < 7; t++) begin
      fill_uniform(tbl[t]);
      run(tbl[t].op, {tbl[t].kr, tbl[t].ki}, tbl[t].n, 1'b0, $sformatf("vec%0d", t));
    end

    // N=19: three beats, last beat keeps lanes 0..2 only. a=0 so r=b.
    fill_seq(19, 32'h0, 16'h0000, 16'h0000, 1'b0);
    run(1'b0, {16'h0300, 16'h0100}, 19, 1'b0, "len19");

    // out_ready 1,0,0,1 pattern; a=(1,0), k=(1,0) gives p=(1.0,0), op=1 so r=b-p.
    fill_seq(20, {16'h0100, 16'h0000}, 16'h0100, 16'h0000, 1'b1);
    run(1'b1, {16'h0100, 16'h0000}, 20, 1'b1, "stall");

    // Empty run: DONE immediately, no data.
    a_q.delete(); b_q.delete(); e_q.delete(); m_q.delete();
    run(1'b0, {16'h0100, 16'h0000}, 0, 1'b0, "len0");

    // Reset in the middle of a run: outputs clear next cycle, no finish afterwards.
    fill_seq(19, 32'h0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 1'b0; constant = {16'h0100, 16'h0000}; vec_len = LEN_W'(19);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; first_row_input = a_q[0]; second_row_input = b_q[0];
    repeat (4) @(negedge clk);
    #1;
    chk("midrun_valid_before_reset", 256'(out_valid), 256'(1));
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("midrun_in_ready", 256'(in_ready), 256'(0));
    chk("midrun_out_valid", 256'(out_valid), 256'(0));
    chk("midrun_result", 256'(result), 256'(0));
    chk("midrun_out_mask", 256'(out_mask), 256'(0));
    chk("midrun_busy", 256'(busy), 256'(0));
    chk("midrun_finish", 256'(finish), 256'(0));
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_reset_finish_c%0d", c), 256'(finish), 256'(0));
      chk($sformatf("post_reset_out_valid_c%0d", c), 256'(out_valid), 256'(0));
    end
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
